// File: rtl/cpu_ctrl_seq_if.sv
// Instruction-memory fetch handshake between the control sequencer (master) and imem (slave).
interface cpu_ctrl_seq_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32I ALU datapath.
// States: IDLE wait start | FETCH imem handshake | DECODE legality | EXEC alu | WB retire | TRAP absorbing
module cpu_ctrl_seq #(
    parameter int IMEM_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_halt_req,
    cpu_ctrl_seq_if.master     imem,
    output logic [31:0]        o_ir_q,
    output logic               o_ir_we,
    output logic               o_alu_en,
    output logic               o_rf_we,
    output logic [4:0]         o_rf_waddr,
    output logic               o_pc_we,
    output logic               o_busy,
    output logic               o_trap,
    output logic [1:0]         o_trap_cause,
    output logic [2:0]         o_state,
    output logic [CNT_W-1:0]   o_retired_count
);

    localparam int WAIT_W = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_ir;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_halt_pending;
    logic [CNT_W-1:0]   r_retired;
    logic [1:0]         r_trap_cause;
    logic               w_legal;
    logic               w_fetch_timeout;

    always_comb begin
        w_legal = 1'b0;
        case (r_ir[6:0])
            7'b0110011: begin
                case ({r_ir[31:25], r_ir[14:12]})
                    10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                    10'b0000000_110, 10'b0000000_100: w_legal = 1'b1;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                case (r_ir[14:12])
                    3'b000, 3'b111, 3'b110, 3'b100: w_legal = 1'b1;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_fetch_timeout = (IMEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_start && !i_halt_req) w_next_state = S_FETCH;
            S_FETCH: begin
                // a late ack in the final allowed cycle wins over the timeout
                if (imem.imem_ack)        w_next_state = S_DECODE;
                else if (w_fetch_timeout) w_next_state = S_TRAP;
            end
            S_DECODE: w_next_state = w_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_next_state = S_WB;
            S_WB:     w_next_state = (r_halt_pending || i_halt_req) ? S_IDLE : S_FETCH;
            S_TRAP:   w_next_state = S_TRAP;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        o_ir_we       = 1'b0;
        o_alu_en      = 1'b0;
        o_pc_we       = 1'b0;
        o_rf_we       = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                o_ir_we       = imem.imem_ack;
            end
            S_EXEC: o_alu_en = 1'b1;
            S_WB: begin
                o_pc_we = 1'b1;
                o_rf_we = (r_ir[11:7] != 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir           <= 32'd0;
            r_wait_cnt     <= '0;
            r_halt_pending <= 1'b0;
            r_retired      <= '0;
            r_trap_cause   <= 2'b00;
        end else begin
            if (r_state == S_FETCH && imem.imem_ack)
                r_ir <= imem.imem_rdata;

            if (r_state == S_FETCH && !imem.imem_ack)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            else
                r_wait_cnt <= '0;

            if (r_state == S_IDLE)
                r_halt_pending <= 1'b0;
            else if (r_state != S_TRAP && i_halt_req)
                r_halt_pending <= 1'b1;

            if (r_state == S_WB)
                r_retired <= r_retired + CNT_W'(1);

            if (r_state == S_FETCH && !imem.imem_ack && w_fetch_timeout)
                r_trap_cause <= 2'b10;
            else if (r_state == S_DECODE && !w_legal)
                r_trap_cause <= 2'b01;
        end
    end

    assign o_ir_q          = r_ir;
    assign o_rf_waddr      = r_ir[11:7];
    assign o_busy          = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign o_trap          = (r_state == S_TRAP);
    assign o_trap_cause    = r_trap_cause;
    assign o_state         = r_state;
    assign o_retired_count = r_retired;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: retire, rd=x0, halt, illegal traps, fetch timeout, async reset.
module tb_cpu_ctrl_seq;

    localparam logic [31:0] I_ADDI1  = 32'h00500093;
    localparam logic [31:0] I_ADD2   = 32'h00108133;
    localparam logic [31:0] I_ADDIX0 = 32'h00100013;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_SLL    = 32'h00209133;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic [31:0] ir_q;
    logic        ir_we;
    logic        alu_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        pc_we;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired;

    logic [31:0] instr;
    bit          ack_enable;
    int          ack_delay;
    int          fcnt;
    int          n_asserts;
    int          n_fail;

    cpu_ctrl_seq_if mif ();

    cpu_ctrl_seq #(.IMEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_halt_req      (halt),
        .imem            (mif.master),
        .o_ir_q          (ir_q),
        .o_ir_we         (ir_we),
        .o_alu_en        (alu_en),
        .o_rf_we         (rf_we),
        .o_rf_waddr      (rf_waddr),
        .o_pc_we         (pc_we),
        .o_busy          (busy),
        .o_trap          (trap),
        .o_trap_cause    (trap_cause),
        .o_state         (state),
        .o_retired_count (retired)
    );

    // instruction memory: acks after ack_delay unacknowledged request cycles
    assign mif.imem_ack   = mif.imem_req && ack_enable && (fcnt == ack_delay);
    assign mif.imem_rdata = instr;

    always @(posedge clk) begin
        if (mif.imem_req && !mif.imem_ack) fcnt <= fcnt + 1;
        else                               fcnt <= 0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_asserts = 0;
        n_fail = 0;
        fcnt = 0;
        rst = 1'b1;
        start = 1'b0;
        halt = 1'b0;
        ack_enable = 1'b1;
        ack_delay = 0;
        instr = I_ADDI1;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", ir_q, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mif.imem_req), 32'd0);
        check("rst_pc_we", 32'(pc_we), 32'd0);

        rst = 1'b0;
        tick();
        check("idle_hold", 32'(state), 32'd0);

        // basic retire: ADDI x1 then ADD x2
        start = 1'b1;
        tick();
        check("i1_fetch", 32'(state), 32'd1);
        check("i1_req", 32'(mif.imem_req), 32'd1);
        check("i1_ir_we", 32'(ir_we), 32'd1);
        check("i1_busy", 32'(busy), 32'd1);
        tick();
        check("i1_decode", 32'(state), 32'd2);
        check("i1_ir", ir_q, I_ADDI1);
        tick();
        check("i1_exec", 32'(state), 32'd3);
        check("i1_alu_en", 32'(alu_en), 32'd1);
        check("i1_exec_pc_we", 32'(pc_we), 32'd0);
        instr = I_ADD2;
        tick();
        check("i1_wb", 32'(state), 32'd4);
        check("i1_pc_we", 32'(pc_we), 32'd1);
        check("i1_rf_we", 32'(rf_we), 32'd1);
        check("i1_waddr", 32'(rf_waddr), 32'd1);
        check("i1_wb_retired", retired, 32'd0);
        tick();
        check("i2_fetch", 32'(state), 32'd1);
        check("i1_retired", retired, 32'd1);
        tick();
        check("i2_ir", ir_q, I_ADD2);
        tick();
        check("i2_exec", 32'(state), 32'd3);
        instr = I_ADDIX0;
        tick();
        check("i2_rf_we", 32'(rf_we), 32'd1);
        check("i2_waddr", 32'(rf_waddr), 32'd2);
        tick();
        check("i2_retired", retired, 32'd2);

        // rd = x0: pc advances, no register write
        tick(); tick();
        check("i3_exec", 32'(state), 32'd3);
        instr = I_ADDI1;
        tick();
        check("i3_wb", 32'(state), 32'd4);
        check("i3_pc_we", 32'(pc_we), 32'd1);
        check("i3_rf_we", 32'(rf_we), 32'd0);
        tick();
        check("i3_retired", retired, 32'd3);

        // halt pulse during EXEC
        tick(); tick();
        check("i4_exec", 32'(state), 32'd3);
        halt = 1'b1;
        start = 1'b0;
        tick();
        check("i4_wb", 32'(state), 32'd4);
        check("i4_pc_we", 32'(pc_we), 32'd1);
        halt = 1'b0;
        tick();
        check("halt_idle", 32'(state), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_retired", retired, 32'd4);
        tick();
        check("halt_stay", 32'(state), 32'd0);

        // resume into an illegal instruction (ECALL)
        instr = I_ECALL;
        start = 1'b1;
        tick();
        check("resume_fetch", 32'(state), 32'd1);
        tick();
        check("ecall_decode", 32'(state), 32'd2);
        check("ecall_ir", ir_q, I_ECALL);
        tick();
        check("ecall_trap_state", 32'(state), 32'd5);
        check("ecall_trap", 32'(trap), 32'd1);
        check("ecall_cause", 32'(trap_cause), 32'd1);
        check("ecall_pc_we", 32'(pc_we), 32'd0);
        check("ecall_rf_we", 32'(rf_we), 32'd0);
        check("ecall_busy", 32'(busy), 32'd0);
        check("ecall_retired", retired, 32'd4);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("trap_sticky", 32'(state), 32'd5);
        check("trap_req", 32'(mif.imem_req), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_retired", retired, 32'd0);
        check("trap_rst_cause", 32'(trap_cause), 32'd0);
        check("trap_rst_trap", 32'(trap), 32'd0);
        tick();
        rst = 1'b0;

        // fetch timeout with ack withheld
        ack_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to_state", 32'(state), 32'd1);
            check("to_req", 32'(mif.imem_req), 32'd1);
        end
        tick();
        check("to_trap", 32'(state), 32'd5);
        check("to_cause", 32'(trap_cause), 32'd2);
        check("to_req_off", 32'(mif.imem_req), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // ack on the final allowed cycle, then SLL trips the decoder
        ack_enable = 1'b1;
        ack_delay = 3;
        instr = I_SLL;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("late_wait", 32'(state), 32'd1);
            check("late_ir_we0", 32'(ir_we), 32'd0);
        end
        tick();
        check("late_last", 32'(state), 32'd1);
        check("late_ir_we1", 32'(ir_we), 32'd1);
        tick();
        check("late_decode", 32'(state), 32'd2);
        check("late_ir", ir_q, I_SLL);
        tick();
        check("sll_trap", 32'(state), 32'd5);
        check("sll_cause", 32'(trap_cause), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack_delay = 0;
        instr = I_ADDI1;

        // async reset in the middle of EXEC
        tick(); tick(); tick(); tick(); tick();
        check("ar_retired1", retired, 32'd1);
        tick(); tick();
        check("ar_exec", 32'(state), 32'd3);
        check("ar_alu_en", 32'(alu_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_alu_off", 32'(alu_en), 32'd0);
        check("ar_rf_we", 32'(rf_we), 32'd0);
        check("ar_pc_we", 32'(pc_we), 32'd0);
        check("ar_retired", retired, 32'd0);
        check("ar_ir", ir_q, 32'd0);
        tick();
        check("ar_hold_pc_we", 32'(pc_we), 32'd0);
        check("ar_hold_state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Multi-cycle control sequencer for the RV32I integer datapath (register file plus ALU, R-type and I-type ALU ops). It replaces free-running single-cycle PC stepping with an explicit FETCH/DECODE/EXEC/WB state machine. It handshakes with instruction memory, issues the datapath enable strobes, and traps on illegal encodings or fetch timeout. It sits between the instruction memory port and the existing PC/register-file/ALU datapath.

Parameters:
IMEM_TIMEOUT, 16, max consecutive FETCH cycles without imem_ack before trap; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  level; leave IDLE and begin fetching
halt_req  input  1  request stop after current instruction retires
imem_req  output  1  instruction fetch request, high throughout FETCH
imem_ack  input  1  fetch data valid this cycle (sampled only in FETCH)
imem_rdata  input  32  fetched instruction
ir_q  output  32  latched instruction register
ir_we  output  1  pulse when ir_q captures imem_rdata
alu_en  output  1  latch ALU result register (EXEC)
rf_we  output  1  register-file write strobe (WB, legal op, rd!=0)
rf_waddr  output  5  ir_q[11:7]
pc_we  output  1  PC <= PC+4 strobe (WB)
busy  output  1  state not IDLE and not TRAP
trap  output  1  sticky, high in TRAP
trap_cause  output  2  00 none, 01 illegal instruction, 10 fetch timeout
state  output  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 TRAP=5
retired_count  output  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): state=IDLE, ir_q=0, retired_count=0, trap_cause=00, wait counter=0, halt_pending=0. All strobes low while in reset. Reset mid-instruction aborts it with no rf_we and no pc_we.
- Strobes are decoded from state: imem_req=(FETCH), ir_we=(FETCH & imem_ack), alu_en=(EXEC), pc_we=(WB), rf_we=(WB & rf_waddr!=0). Only legal instructions reach WB.
- IDLE: if start & !halt_req go to FETCH; otherwise stay. halt_pending is cleared in IDLE.
- FETCH: if imem_ack, ir_q<=imem_rdata, clear the wait counter, go to DECODE.
  - Otherwise the wait counter increments.
  - If IMEM_TIMEOUT!=0 and the counter==IMEM_TIMEOUT-1 with no ack: go to TRAP with cause 10.
  - An ack arriving in that same final cycle takes priority, so at most IMEM_TIMEOUT cycles are allowed.
- DECODE: legality check on ir_q.
  - Legal: opcode 0110011 with {funct7,funct3} in {0000000_000, 0100000_000, 0000000_111, 0000000_110, 0000000_100}.
  - Legal: opcode 0010011 with funct3 in {000, 111, 110, 100}.
  - Legal goes to EXEC. Anything else goes to TRAP with cause 01, with no pc_we and no rf_we.
- EXEC: go to WB unconditionally.
- WB: retired_count+1. Next state is IDLE if (halt_pending | halt_req), else FETCH.
- halt_req is sampled every non-IDLE, non-TRAP cycle and sets halt_pending. The current instruction always completes, so halt never aborts mid-instruction.
- TRAP: absorbing. trap=1, all strobes 0, start ignored. Exit only via rst.
- Throughput: 4 cycles per instruction when imem_ack is returned in the first FETCH cycle. Each additional ack wait cycle adds 1 cycle.
- No interaction with x0 beyond rf_we suppression; the datapath still masks x0 reads.

Test Plan:
- Basic retire: reset, start=1, ack in the first FETCH cycle. Program: ADDI x1,x0,5 (0x00500093); ADD x2,x1,x1 (0x00108133). Required: state sequence 1,2,3,4 repeating; rf_we at WB with rf_waddr 1 then 2; pc_we once per 4 cycles; retired_count=2 after 8 cycles.
- rd=x0: ADDI x0,x0,1 (0x00100013). Required: reaches WB with pc_we=1, rf_we=0, retired_count increments.
- Illegal: fetch 0x00000073 (ECALL) or SLL 0x00209133. Required: DECODE goes to TRAP; trap=1, trap_cause=01; no pc_we/rf_we; start toggling keeps TRAP; rst returns to IDLE with retired_count=0.
- Fetch timeout: IMEM_TIMEOUT=4, ack withheld. Required: imem_req high for 4 cycles, then TRAP with cause 10. A second run with ack on the 4th cycle is accepted and proceeds to DECODE.
- Halt: pulse halt_req for 1 cycle during EXEC of instruction n. Required: instruction n retires, then IDLE; busy=0; next start resumes with FETCH.
- Async reset in EXEC: assert rst between edges. Required: state=0 immediately, alu_en/rf_we/pc_we low, retired_count=0, no write observed.
